// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, vote-tap position helpers and the
// parameter legality rules used by the UART oversampling front end.
package uart_pkg;

  // Receiver alignment state: hunting for a start edge, or tracking bit phase
  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Phase of the earliest vote tap, centred on the middle of the bit
  function automatic int first_tap(input int os, input int vt);
    return os / 2 - vt / 2;
  endfunction

  // Phase of the last vote tap; the majority decision is taken on this baud
  function automatic int vote_phase(input int os, input int vt);
    return os / 2 + vt / 2;
  endfunction

  // Legal parameter space: even oversampling >= 4, at least two synchroniser
  // flops, an odd tap count that fits strictly after the start-detect sample
  function automatic bit params_legal(input int os, input int ss, input int vt);
    return (os >= 4) && (os % 2 == 0) && (ss >= 2) &&
           (vt >= 1) && (vt % 2 == 1) && (vt <= os - 1) &&
           (first_tap(os, vt) >= 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchroniser for an asynchronous serial input.
// Flops reset to 1 so an idle-high line never looks like a start edge.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw line through the chain every clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '1;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_oversampler.sv
// uart_oversampler: hunts for a start edge on an oversampled serial line,
// then tracks bit phase and emits one majority-voted bit per bit period.
module uart_oversampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int VOTE_TAPS    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic baud,
  input  logic in,
  input  logic realign,
  output logic bit_out,
  output logic bit_valid,
  output logic noise,
  output logic false_start,
  output logic locked
);

  localparam int PW = $clog2(OVERSAMPLING);
  localparam int CW = $clog2(VOTE_TAPS + 1);
  localparam logic [PW-1:0] VP   = PW'(vote_phase(OVERSAMPLING, VOTE_TAPS));
  localparam logic [PW-1:0] LAST = PW'(OVERSAMPLING - 1);

  if (!params_legal(OVERSAMPLING, SYNC_STAGES, VOTE_TAPS)) begin : g_illegal_params
    $error("uart_oversampler: illegal OVERSAMPLING/SYNC_STAGES/VOTE_TAPS combination");
  end

  logic                 s_in;
  logic [VOTE_TAPS-1:0] window_nx;
  logic [CW-1:0]        ones;
  logic                 majority;
  logic                 disagree;
  logic [PW-1:0]        phase;
  logic [PW-1:0]        phase_nx;
  logic                 first_bit;
  state_t               state;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (in),
    .q  (s_in)
  );

  // The vote window is the VOTE_TAPS-1 older samples plus the sample arriving
  // on this baud, so the decision on the last tap includes that tap itself.
  if (VOTE_TAPS == 1) begin : g_single_tap
    assign window_nx = s_in;
  end else begin : g_multi_tap
    logic [VOTE_TAPS-2:0] history;

    // Shift the synchronised line into the sample history on every baud
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)      history <= '1;
      else if (baud) history <= window_nx[VOTE_TAPS-2:0];
    end

    assign window_nx = {history, s_in};
  end

  // Count ones in the window for the majority decision
  always_comb begin
    ones = '0;
    for (int i = 0; i < VOTE_TAPS; i++) begin
      ones = ones + CW'(window_nx[i]);
    end
  end

  assign majority = (ones > CW'(VOTE_TAPS / 2));
  assign disagree = !((&window_nx) || !(|window_nx));
  assign phase_nx = (phase == LAST) ? '0 : phase + PW'(1);

  // Hunt/track state machine with registered strobes and decoded bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HUNT;
      phase       <= '0;
      first_bit   <= 1'b0;
      bit_out     <= 1'b1;
      bit_valid   <= 1'b0;
      noise       <= 1'b0;
      false_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      bit_valid   <= 1'b0;
      noise       <= 1'b0;
      false_start <= 1'b0;
      case (state)
        HUNT: begin
          // The sample that shows the falling edge is phase 0 of the start bit
          if (baud && !s_in) begin
            state     <= TRACK;
            phase     <= '0;
            first_bit <= 1'b1;
            locked    <= 1'b1;
          end
        end
        TRACK: begin
          if (realign) begin
            // Frame logic wins over any vote due on this same edge
            state     <= HUNT;
            phase     <= '0;
            first_bit <= 1'b0;
            locked    <= 1'b0;
          end else if (baud) begin
            phase <= phase_nx;
            if (phase_nx == VP) begin
              if (first_bit && majority) begin
                // Start bit did not hold low through its centre: glitch
                false_start <= 1'b1;
                state       <= HUNT;
                phase       <= '0;
                first_bit   <= 1'b0;
                locked      <= 1'b0;
              end else begin
                bit_out   <= majority;
                bit_valid <= 1'b1;
                noise     <= disagree;
                first_bit <= 1'b0;
              end
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
